pattern_search_engine: RTL and testbench

- Responder side of the pattern-match handshake: the search controller raises inc_flag, and this block walks the pattern memory address by address.
- Compares each word against the captured pattern and reports done_flag with match_address and found.
- Sits between the search controller and a synchronous single-port pattern RAM with one-cycle read latency.

---
 rtl/pattern_search_engine.sv | 133 +++++++++++++
 tb/tb_pattern_search_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_search_engine.sv
// Pattern search responder: walks pattern RAM from address 0 and reports the first match.
// Optional PATTERN_MASK_EN adds a per-bit don't-care mask captured alongside the pattern.
module pattern_search_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LAST_ADDR  = 511
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inc_flag,
    input  logic [DATA_WIDTH-1:0] pattern,
`ifdef PATTERN_MASK_EN
    input  logic [DATA_WIDTH-1:0] pattern_mask,
`endif
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  done_flag,
    output logic [ADDR_WIDTH-1:0] match_address,
    output logic                  found
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic                  found_q, found_d;
    logic                  mem_rd_q, done_q;
    logic                  hit_c;

`ifdef PATTERN_MASK_EN
    logic [DATA_WIDTH-1:0] mask_q, mask_d;

    // Cleared mask bits are don't-care positions
    assign hit_c = ((mem_data ^ pattern_q) & mask_q) == '0;
`else
    assign hit_c = (mem_data == pattern_q);
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pattern_d = pattern_q;
        found_d   = found_q;
`ifdef PATTERN_MASK_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (inc_flag) begin
                    addr_d    = '0;
                    pattern_d = pattern;
                    found_d   = 1'b0;
`ifdef PATTERN_MASK_EN
                    mask_d    = pattern_mask;
`endif
                    state_d   = READ;
                end
            end
            READ: begin
                if (!inc_flag) begin
                    found_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A dropped request wins over whatever the RAM returned
                if (!inc_flag) begin
                    found_d = 1'b0;
                    state_d = IDLE;
                end else if (hit_c) begin
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (addr_q == LAST_A) begin
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                if (!inc_flag) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pattern_q <= '0;
            found_q   <= 1'b0;
            mem_rd_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef PATTERN_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pattern_q <= pattern_d;
            found_q   <= found_d;
            mem_rd_q  <= (state_d == READ);
            done_q    <= (state_d == DONE);
`ifdef PATTERN_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign mem_rd        = mem_rd_q;
    assign mem_addr      = addr_q;
    assign match_address = addr_q;
    assign done_flag     = done_q;
    assign found         = found_q;

endmodule

// File: tb/tb_pattern_search_engine.sv
// Self-checking bench for pattern_search_engine: directed table, reset/abort sequences, random searches.
module tb_pattern_search_engine;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 9;
    localparam int          LAST = 511;

    logic          clock = 1'b0;
    logic          reset;
    logic          inc_flag;
    logic [DW-1:0] pattern;
`ifdef PATTERN_MASK_EN
    logic [DW-1:0] pattern_mask;
`endif
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          done_flag;
    logic [AW-1:0] match_address;
    logic          found;

    logic [DW-1:0] ram [0:LAST];
    int            reads[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pattern_search_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LAST)) dut (
        .clock         (clock),
        .reset         (reset),
        .inc_flag      (inc_flag),
        .pattern       (pattern),
`ifdef PATTERN_MASK_EN
        .pattern_mask  (pattern_mask),
`endif
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .done_flag     (done_flag),
        .match_address (match_address),
        .found         (found)
    );

    // Synchronous RAM, one-cycle read latency
    always @(posedge clock) if (mem_rd) mem_data <= ram[mem_addr];

    always @(negedge clock) if (mem_rd === 1'b1) reads.push_back(int'(mem_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fill_ram(input logic [DW-1:0] v);
        for (int i = 0; i <= LAST; i++) ram[i] = v;
    endtask

    // Reference: first address whose word matches under the effective mask
    function automatic void model(input logic [DW-1:0] pat, input logic [DW-1:0] msk,
                                  output bit f, output int a, output int cyc);
        logic [DW-1:0] em;
`ifdef PATTERN_MASK_EN
        em = msk;
`else
        em = msk | 8'hFF;
`endif
        f = 1'b0;
        a = LAST;
        for (int i = 0; i <= LAST; i++) begin
            if (((ram[i] ^ pat) & em) == '0) begin
                f = 1'b1;
                a = i;
                break;
            end
        end
        cyc = 2 * a + 3;
    endfunction

    task automatic run_search(input string tag, input logic [DW-1:0] pat, input logic [DW-1:0] msk,
                              input bit ef, input int ea, input int ecyc);
        int cyc;
        int bad;
        reads.delete();
        pattern  = pat;
`ifdef PATTERN_MASK_EN
        pattern_mask = msk;
`endif
        inc_flag = 1'b1;
        cyc = 0;
        while (done_flag !== 1'b1 && cyc < 1100) begin
            step();
            cyc++;
            if (cyc == 1) pattern = ~pat;
        end
        check({tag, " done_cycle"}, 32'(cyc), 32'(ecyc));
        check({tag, " found"}, 32'(found), 32'(ef));
        check({tag, " match_address"}, 32'(match_address), 32'(ea));
        check({tag, " read_count"}, 32'(reads.size()), 32'(ea + 1));
        bad = 0;
        foreach (reads[i]) if (reads[i] != i) bad++;
        check({tag, " read_order_errors"}, 32'(bad), 32'd0);
        inc_flag = 1'b0;
        step();
        check({tag, " done_drop"}, 32'(done_flag), 32'd0);
        check({tag, " found_hold"}, 32'(found), 32'(ef));
        check({tag, " addr_hold"}, 32'(match_address), 32'(ea));
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] fill;
        int            sp_addr;
        logic [DW-1:0] sp_val;
        logic [DW-1:0] pat;
        logic [DW-1:0] msk;
        bit            ef;
        int            ea;
        int            ecyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit f;
        int a;
        int c;
        int seen;
        logic [DW-1:0] p;
        logic [DW-1:0] m;

        vecs[0] = '{"match_at_0",   8'h00, 0,   8'hA5, 8'hA5, 8'hFF, 1'b1, 0,   3};
        vecs[1] = '{"match_at_37",  8'h00, 37,  8'h3C, 8'h3C, 8'hFF, 1'b1, 37,  77};
        vecs[2] = '{"full_miss",    8'h00, 0,   8'h00, 8'hFF, 8'hFF, 1'b0, 511, 1025};
        vecs[3] = '{"match_at_511", 8'h55, 511, 8'hAA, 8'hAA, 8'hFF, 1'b1, 511, 1025};
`ifdef PATTERN_MASK_EN
        vecs[4] = '{"masked_5",     8'h00, 5,   8'hA7, 8'hA0, 8'hF0, 1'b1, 5,   13};
`else
        vecs[4] = '{"masked_5",     8'h00, 5,   8'hA7, 8'hA0, 8'hF0, 1'b0, 511, 1025};
`endif

        reset    = 1'b0;
        inc_flag = 1'b0;
        pattern  = '0;
`ifdef PATTERN_MASK_EN
        pattern_mask = '1;
`endif
        fill_ram(8'h00);
        step(2);
        check("rst done_flag", 32'(done_flag), 32'd0);
        check("rst found", 32'(found), 32'd0);
        check("rst match_address", 32'(match_address), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        step();

        // Reset while in CHECK of address 20
        pattern  = 8'hFF;
        inc_flag = 1'b1;
        step(42);
        check("midsearch match_address", 32'(match_address), 32'd20);
        check("midsearch mem_rd", 32'(mem_rd), 32'd0);
        reset = 1'b0;
        #1;
        check("async rst done_flag", 32'(done_flag), 32'd0);
        check("async rst found", 32'(found), 32'd0);
        check("async rst match_address", 32'(match_address), 32'd0);
        check("async rst mem_rd", 32'(mem_rd), 32'd0);
        inc_flag = 1'b0;
        step();
        reset = 1'b1;
        seen = 0;
        repeat (4) begin
            step();
            if (mem_rd !== 1'b0 || done_flag !== 1'b0) seen++;
        end
        check("post rst idle activity", 32'(seen), 32'd0);

        foreach (vecs[i]) begin
            fill_ram(vecs[i].fill);
            ram[vecs[i].sp_addr] = vecs[i].sp_val;
            run_search(vecs[i].name, vecs[i].pat, vecs[i].msk, vecs[i].ef, vecs[i].ea, vecs[i].ecyc);
        end

        // Abort during a search, then restart with a new pattern
        fill_ram(8'h00);
        pattern  = 8'h77;
        inc_flag = 1'b1;
        step(10);
        inc_flag = 1'b0;
        step();
        check("abort mem_rd", 32'(mem_rd), 32'd0);
        check("abort found", 32'(found), 32'd0);
        check("abort done_flag", 32'(done_flag), 32'd0);
        check("abort addr_hold", 32'(match_address), 32'd4);
        seen = 0;
        repeat (5) begin
            step();
            if (done_flag !== 1'b0 || mem_rd !== 1'b0) seen++;
        end
        check("abort stays idle", 32'(seen), 32'd0);
        ram[2] = 8'h42;
        run_search("restart", 8'h42, 8'hFF, 1'b1, 2, 7);

        // Random contents against the reference model
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i <= LAST; i++) ram[i] = 8'($urandom_range(0, 15));
            p = 8'($urandom_range(0, 15)) | ((it % 3 == 0) ? 8'h80 : 8'h00);
            m = 8'($urandom) | 8'h80;
            model(p, m, f, a, c);
            run_search($sformatf("rand%0d", it), p, m, f, a, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
